// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Multi-channel LED sequencer for the front-panel LEDs. Every channel has its
// own mode (off / on / loop / one-shot) and its own step pattern, which can be
// rewritten at run time. A shared step counter walks through the P steps of
// the patterns. It is advanced by an internal clock divider, so the whole
// block runs on 'clock' alone and no derived clock is generated. Maintenance
// mode forces every LED on without disturbing the sequencing.
//
// Parameters
//   NUM_LEDS      number of LED channels (1..16)
//   STEP_DIV      clock cycles per pattern step (>= 2)
//   STEP_BITS     step counter width; pattern length P = 2**STEP_BITS
//   PATTERN_INIT  reset patterns, NUM_LEDS*P bits, LED0 in the LSBs
//
// Ports
//   clock       in   1           system clock
//   reset       in   1           asynchronous, active-low reset
//   led_mode    in   2*NUM_LEDS  per-LED mode [2i+1:2i]: 00 off, 01 on,
//                                10 loop, 11 one-shot
//   wr_en       in   1           single-cycle pattern write strobe
//   wr_sel      in   SEL_W       target LED of a pattern write
//   wr_pattern  in   P           new pattern, bit s = LED state at step s
//   restart     in   1           synchronous re-sequence strobe
//   mtne_mode   in   1           maintenance mode, all LEDs on
//   led_output  out  NUM_LEDS    registered LED drive, 1 = on
//   step        out  STEP_BITS   current step index
//   step_tick   out  1           one-cycle pulse after each step advance
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int NUM_LEDS  = 6,
    parameter int STEP_DIV  = 10000000,
    parameter int STEP_BITS = 4,
    parameter logic [NUM_LEDS*(2**STEP_BITS)-1:0] PATTERN_INIT =
        {16'h9248, 16'h4924, 16'hFFFF, 16'h2492, 16'h1111, 16'hFFFF},
    localparam int P     = 2**STEP_BITS,
    localparam int SEL_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2*NUM_LEDS-1:0]  led_mode,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [P-1:0]           wr_pattern,
    input  logic                   restart,
    input  logic                   mtne_mode,
    output logic [NUM_LEDS-1:0]    led_output,
    output logic [STEP_BITS-1:0]   step,
    output logic                   step_tick
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    // -------------------------------------------------------------------------
    // Step divider and step counter
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [DIV_W-1:0]     div_cnt_next;
    logic [STEP_BITS-1:0] step_reg;
    logic [STEP_BITS-1:0] step_next;
    logic                 step_tick_reg;
    logic                 step_tick_next;
    logic                 tick;
    logic                 wrap;

    // tick is high in the final divider cycle of a step; the step advances on
    // the edge that ends that cycle.
    assign tick = (div_cnt_reg == DIV_LAST);

    // A wrap is the tick that takes the last step back to step 0. One-shot
    // channels use it to mark their single pass as finished.
    assign wrap = tick && (step_reg == {STEP_BITS{1'b1}});

    always_comb begin
        div_cnt_next   = div_cnt_reg + DIV_W'(1);
        step_next      = step_reg;
        step_tick_next = 1'b0;
        if (restart) begin
            // restart takes priority over a coincident tick: the step does not
            // advance and no step_tick is produced.
            div_cnt_next = '0;
            step_next    = '0;
        end else if (tick) begin
            div_cnt_next   = '0;
            step_next      = step_reg + STEP_BITS'(1);
            step_tick_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt_reg   <= '0;
            step_reg      <= '0;
            step_tick_reg <= 1'b0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            step_reg      <= step_next;
            step_tick_reg <= step_tick_next;
        end
    end

    assign step      = step_reg;
    assign step_tick = step_tick_reg;

    // -------------------------------------------------------------------------
    // Per-channel state: pattern, one-shot tracking and output register
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic [P-1:0] pattern_reg;
            logic [P-1:0] pattern_next;
            logic [1:0]   mode_q_reg;
            logic [1:0]   mode_in;
            logic         done_reg;
            logic         done_next;
            logic         led_reg;
            logic         led_next;
            logic         pat_bit;
            logic         mode_changed;

            assign mode_in      = led_mode[2*gi +: 2];
            assign pat_bit      = pattern_reg[step_reg];
            assign mode_changed = (mode_in != mode_q_reg);

            // Writes addressed to a non-existent channel (wr_sel >= NUM_LEDS)
            // simply match no channel and are dropped.
            always_comb begin
                pattern_next = pattern_reg;
                if (wr_en && (wr_sel == SEL_W'(gi))) begin
                    pattern_next = wr_pattern;
                end
            end

            // Any mode change re-arms the one-shot, so toggling a channel out
            // of one-shot and back plays the pattern again. Clearing wins over
            // a simultaneous wrap.
            always_comb begin
                done_next = done_reg;
                if (restart || mode_changed) begin
                    done_next = 1'b0;
                end else if (wrap && (mode_in == 2'b11)) begin
                    done_next = 1'b1;
                end
            end

            // The output is computed from pre-edge state, so led_output lags
            // any step, pattern, mode or done change by exactly one clock.
            always_comb begin
                led_next = 1'b0;
                if (mtne_mode) begin
                    led_next = 1'b1;
                end else begin
                    case (mode_in)
                        2'b00:   led_next = 1'b0;
                        2'b01:   led_next = 1'b1;
                        2'b10:   led_next = pat_bit;
                        default: led_next = pat_bit && !done_reg;
                    endcase
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    pattern_reg <= PATTERN_INIT[gi*P +: P];
                    mode_q_reg  <= 2'b00;
                    done_reg    <= 1'b0;
                    led_reg     <= 1'b0;
                end else begin
                    pattern_reg <= pattern_next;
                    mode_q_reg  <= mode_in;
                    done_reg    <= done_next;
                    led_reg     <= led_next;
                end
            end

            assign led_output[gi] = led_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

    localparam int NUM_LEDS  = 6;
    localparam int STEP_DIV  = 4;
    localparam int STEP_BITS = 4;
    localparam int P         = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] led_mode = 12'h000;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = 3'd0;
    logic [15:0] wr_pattern = 16'h0000;
    logic        restart = 1'b0;
    logic        mtne_mode = 1'b0;
    logic [5:0]  led_output;
    logic [3:0]  step;
    logic        step_tick;

    always #5 clock = ~clock;

    led_pattern_ctrl #(
        .NUM_LEDS  (NUM_LEDS),
        .STEP_DIV  (STEP_DIV),
        .STEP_BITS (STEP_BITS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .led_mode   (led_mode),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_pattern (wr_pattern),
        .restart    (restart),
        .mtne_mode  (mtne_mode),
        .led_output (led_output),
        .step       (step),
        .step_tick  (step_tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: expected divider/step/tick/LEDs and stored patterns.
    logic [15:0] init_pat [6];
    logic [15:0] m_pat [6];
    int          m_div;
    int          m_step;
    logic        m_tick;
    logic [5:0]  m_led;
    logic [5:0]  cmp_mask = 6'h3F;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_div  = 0;
        m_step = 0;
        m_tick = 1'b0;
        m_led  = 6'h00;
        m_pat  = init_pat;
    endtask

    // Advance one clock, then update the expected values from the inputs
    // and state that were present before the edge.
    task automatic clk_step();
        logic [5:0]  led_n;
        logic [1:0]  md;
        logic        tk;
        logic        rs;
        logic        we;
        logic [2:0]  ws;
        logic [15:0] wp;
        for (int i = 0; i < NUM_LEDS; i++) begin
            md = led_mode[2*i +: 2];
            case (md)
                2'b00:   led_n[i] = 1'b0;
                2'b01:   led_n[i] = 1'b1;
                default: led_n[i] = m_pat[i][m_step];
            endcase
        end
        if (mtne_mode) led_n = 6'h3F;
        tk = (m_div == STEP_DIV - 1);
        rs = restart;
        we = wr_en;
        ws = wr_sel;
        wp = wr_pattern;
        @(posedge clock);
        #1;
        m_led = led_n;
        if (rs) begin
            m_div  = 0;
            m_step = 0;
            m_tick = 1'b0;
        end else begin
            m_tick = tk;
            m_div  = tk ? 0 : m_div + 1;
            if (tk) m_step = (m_step + 1) % P;
        end
        if (we && (ws < 3'd6)) m_pat[ws] = wp;
    endtask

    task automatic check_cycle(input string tag);
        chk({tag, "_step"}, 32'(step), 32'(m_step));
        chk({tag, "_tick"}, 32'(step_tick), 32'(m_tick));
        chk({tag, "_led"}, 32'(led_output & cmp_mask), 32'(m_led & cmp_mask));
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            clk_step();
            check_cycle(tag);
        end
    endtask

    // Run until the expected state reaches the given step/divider position,
    // bounded so a stuck design still reaches the summary.
    task automatic wait_pos(input int s, input int d, input string tag);
        int guard;
        guard = 0;
        while (!(m_step == s && m_div == d) && guard < 200) begin
            clk_step();
            check_cycle(tag);
            guard++;
        end
        chk({tag, "_reached"}, 32'(guard < 200), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        int s;
        init_pat = '{16'hFFFF, 16'h1111, 16'h2492, 16'hFFFF, 16'h4924, 16'h9248};
        model_reset();

        // ---- reset state ----
        led_mode = 12'hAAA;
        #2;
        chk("rst_led", 32'(led_output), 32'(0));
        chk("rst_step", 32'(step), 32'(0));
        chk("rst_tick", 32'(step_tick), 32'(0));
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hold_led", 32'(led_output), 32'(0));
        chk("rst_hold_step", 32'(step), 32'(0));
        reset = 1'b1;
        model_reset();

        // ---- 1: all loop mode, step/tick cadence and initial patterns ----
        for (int c = 1; c <= 68; c++) begin
            clk_step();
            check_cycle("t1");
            s = ((c - 1) / 4) % 16;
            chk("t1_step_hand", 32'(step), 32'((c / 4) % 16));
            chk("t1_tick_hand", 32'(step_tick), 32'((c % 4) == 0));
            chk("t1_led1_hand", 32'(led_output[1]), 32'((s % 4) == 0));
            chk("t1_led2_hand", 32'(led_output[2]), 32'((s % 3) == 1));
        end

        // ---- 2: one-shot on LED0 ----
        led_mode[1:0] = 2'b11;
        restart = 1'b1;
        cmp_mask = 6'h3E;
        clk_step();
        check_cycle("t2_rs");
        chk("t2_rs_led0", 32'(led_output[0]), 32'(1));
        restart = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            clk_step();
            check_cycle("t2");
            chk("t2_led0", 32'(led_output[0]), 32'(k <= 64));
        end
        led_mode[1:0] = 2'b10;
        clk_step();
        check_cycle("t2_m10");
        chk("t2_m10_led0", 32'(led_output[0]), 32'(1));
        led_mode[1:0] = 2'b11;
        for (int k = 0; k < 8; k++) begin
            clk_step();
            check_cycle("t2_again");
            chk("t2_again_led0", 32'(led_output[0]), 32'(1));
        end
        led_mode[1:0] = 2'b10;
        clk_step();
        cmp_mask = 6'h3F;
        check_cycle("t2_back");

        // ---- 3: pattern writes ----
        wait_pos(5, 0, "t3_wait");
        wr_en = 1'b1;
        wr_sel = 3'd2;
        wr_pattern = 16'h0001;
        clk_step();
        check_cycle("t3_wr");
        wr_en = 1'b0;
        for (int k = 0; k < 70; k++) begin
            prev = m_step;
            clk_step();
            check_cycle("t3_led2");
            chk("t3_led2_hand", 32'(led_output[2]), 32'(prev == 0));
        end
        wr_en = 1'b1;
        wr_sel = 3'd3;
        wr_pattern = 16'h0000;
        clk_step();
        check_cycle("t3_wr3");
        chk("t3_wr3_led3_old", 32'(led_output[3]), 32'(1));
        wr_en = 1'b0;
        clk_step();
        check_cycle("t3_wr3b");
        chk("t3_wr3_led3_new", 32'(led_output[3]), 32'(0));
        wr_en = 1'b1;
        wr_sel = 3'd7;
        wr_pattern = 16'h0000;
        clk_step();
        check_cycle("t3_sel7");
        wr_sel = 3'd6;
        clk_step();
        check_cycle("t3_sel6");
        wr_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            prev = m_step;
            clk_step();
            check_cycle("t3_ign");
            chk("t3_ign_led1", 32'(led_output[1]), 32'((prev % 4) == 0));
            chk("t3_ign_led5", 32'(led_output[5]), 32'(init_pat[5][prev]));
        end

        // ---- 4: restart in a tick cycle at step 9 ----
        wait_pos(9, 3, "t4_wait");
        restart = 1'b1;
        clk_step();
        restart = 1'b0;
        check_cycle("t4_rs");
        chk("t4_rs_step", 32'(step), 32'(0));
        chk("t4_rs_tick", 32'(step_tick), 32'(0));
        for (int j = 1; j <= 4; j++) begin
            clk_step();
            check_cycle("t4_after");
            chk("t4_after_tick", 32'(step_tick), 32'(j == 4));
            chk("t4_after_step", 32'(step), 32'((j == 4) ? 1 : 0));
        end

        // ---- 5: maintenance mode ----
        led_mode = 12'h000;
        mtne_mode = 1'b1;
        clk_step();
        check_cycle("t5_on");
        chk("t5_on_led", 32'(led_output), 32'(6'h3F));
        run(10, "t5_run");
        chk("t5_run_led", 32'(led_output), 32'(6'h3F));
        mtne_mode = 1'b0;
        clk_step();
        check_cycle("t5_off");
        chk("t5_off_led", 32'(led_output), 32'(0));
        led_mode = 12'h555;
        clk_step();
        check_cycle("t5_m01");
        chk("t5_m01_led", 32'(led_output), 32'(6'h3F));
        led_mode = 12'h000;
        clk_step();
        check_cycle("t5_m00");
        chk("t5_m00_led", 32'(led_output), 32'(0));

        // ---- 6: asynchronous reset mid-sequence ----
        led_mode = 12'hAAA;
        run(10, "t6_pre");
        chk("t6_pre_led0", 32'(led_output[0]), 32'(1));
        reset = 1'b0;
        #1;
        chk("t6_async_led", 32'(led_output), 32'(0));
        chk("t6_async_step", 32'(step), 32'(0));
        chk("t6_async_tick", 32'(step_tick), 32'(0));
        repeat (2) @(posedge clock);
        #1;
        chk("t6_hold_led", 32'(led_output), 32'(0));
        reset = 1'b1;
        model_reset();
        for (int c = 1; c <= 68; c++) begin
            clk_step();
            check_cycle("t6");
            s = ((c - 1) / 4) % 16;
            chk("t6_led2_hand", 32'(led_output[2]), 32'((s % 3) == 1));
            chk("t6_led3_hand", 32'(led_output[3]), 32'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
